// File: rtl/iterative_shifter_pkg.sv
// Shared constants for the iterative shifter and its control-unit clients:
// shift op codes and FSM state encodings.
package iterative_shifter_pkg;

  typedef logic [1:0] shift_op_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/iterative_shifter_if.sv
// Start/busy/valid handshake bundle between the control unit (master)
// and the iterative shifter (slave).
interface iterative_shifter_if
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);

  logic               start;
  shift_op_t          op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data;
  logic               busy;
  logic               valid;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, shamt, data,
    input  busy, valid, result
  );

  modport slave (
    input  start, op, shamt, data,
    output busy, valid, result
  );

endinterface

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single-step shifter: shifts data by amt (0..STEP) using a
// small barrel of $clog2(STEP)+1 power-of-two stages.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AMT_W = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_t        op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] shifted
);

  function automatic logic [WIDTH-1:0] shift_fixed(
    input logic [WIDTH-1:0] x,
    input shift_op_t        o,
    input int               k
  );
    logic [WIDTH-1:0] r;
    unique case (o)
      OP_SLL:  r = x << k;
      OP_SRL:  r = x >> k;
      OP_SRA:  r = $signed(x) >>> k;
      OP_ROR:  r = (x >> k) | (x << (WIDTH - k));
      default: r = x;
    endcase
    return r;
  endfunction

  // Stage i applies a fixed 2**i shift when bit i of amt is set.
  always_comb begin
    shifted = data;
    for (int i = 0; i < AMT_W; i++) begin
      if (amt[i]) shifted = shift_fixed(shifted, op, 1 << i);
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle variable shifter: shifts up to STEP bits per cycle under a
// start/busy/valid handshake; FSM, remaining-count and result register live here.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  iterative_shifter_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int AMT_W   = $clog2(STEP) + 1;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  shift_op_t          op_q;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [AMT_W-1:0]   amt;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   stepped;
  logic               busy;
  logic               valid;
  logic               accept;

  assign accept = bus.start && (state == S_IDLE || state == S_DONE);

  // rem < STEP in the short branch, so the narrowing cast never drops bits.
  always_comb begin
    amt     = (int'(rem) >= STEP) ? AMT_W'(STEP) : AMT_W'(rem);
    rem_nxt = rem - SHAMT_W'(amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data    (result),
    .op      (op_q),
    .amt     (amt),
    .shifted (stepped)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (bus.shamt == '0) ? S_DONE : S_SHIFT;
        else        state_nxt = S_IDLE;
      end
      S_SHIFT: if (rem_nxt == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy/valid are registered from the next state so they align with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      rem    <= '0;
      op_q   <= OP_SLL;
      result <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_SHIFT);
      valid <= (state_nxt == S_DONE);
      if (accept) begin
        result <= bus.data;
        op_q   <= bus.op;
        rem    <= bus.shamt;
      end else if (state == S_SHIFT) begin
        result <= stepped;
        rem    <= rem_nxt;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.valid  = valid;
  assign bus.result = result;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed, table-driven bench for iterative_shifter (WIDTH=32, STEP=4),
// plus handshake/reset sequences and a short randomised run.
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iterative_shifter_if #(.WIDTH(32)) bus ();

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [31:0] exp;
    int          k;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] d);
    logic [31:0] r;
    case (o)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $signed(d) >>> s;
      default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    bus.start = 1'b1;
    bus.op    = o;
    bus.shamt = s;
    bus.data  = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.shamt = 5'd0;
    bus.data  = 32'h5A5A_A5A5;
  endtask

  // n = edges after the accepting edge until valid is seen; b = cycles with busy.
  task automatic wait_valid(output int n, output int b);
    n = 0;
    b = 0;
    while (!bus.valid && n < 64) begin
      if (bus.busy) b++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, b, gap, s;
    logic [1:0]  o;
    logic [31:0] d;

    vecs[0] = '{OP_SLL, 5'd2,  32'h0000_0001, 32'h0000_0004, 1};
    vecs[1] = '{OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 8};
    vecs[2] = '{OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 8};
    vecs[3] = '{OP_ROR, 5'd4,  32'h0000_0001, 32'h1000_0000, 1};
    vecs[4] = '{OP_SLL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[5] = '{OP_ROR, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[6] = '{OP_SRA, 5'd5,  32'h7000_0000, 32'h0380_0000, 2};
    vecs[7] = '{OP_ROR, 5'd9,  32'h0000_0F01, 32'h8080_0007, 3};
    vecs[8] = '{OP_SLL, 5'd31, 32'h0000_0003, 32'h8000_0000, 8};
    vecs[9] = '{OP_SRA, 5'd3,  32'h8000_0010, 32'hF000_0002, 1};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.shamt = 5'd0;
    bus.data  = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_valid", {31'b0, bus.valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].shamt, vecs[i].data);
      wait_valid(n, b);
      chk($sformatf("vec%0d_latency", i), n, vecs[i].k);
      chk($sformatf("vec%0d_busy_cycles", i), b, vecs[i].k);
      chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_single", i), {31'b0, bus.valid}, 32'h0);
      chk($sformatf("vec%0d_result_held", i), bus.result, vecs[i].exp);
    end

    // Start during SHIFT is ignored; start in the DONE cycle is taken.
    drive(OP_SLL, 5'd8, 32'h0000_0001);
    bus.start = 1'b1;
    bus.op    = OP_SRL;
    bus.shamt = 5'd1;
    bus.data  = 32'h0000_00FF;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    b = 0;
    while (!bus.valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_latency", n, 2);
    chk("ignore_result", bus.result, 32'h0000_0100);
    drive(OP_SRL, 5'd1, 32'h0000_00FF);
    wait_valid(n, b);
    chk("b2b_latency", n, 1);
    chk("b2b_result", bus.result, 32'h0000_007F);
    @(negedge clk);

    // Asynchronous reset in the middle of a shift.
    drive(OP_SRA, 5'd20, 32'h8000_0000);
    @(negedge clk);
    chk("pre_reset_busy", {31'b0, bus.busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", bus.result, 32'h0);
    chk("async_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("async_rst_valid", {31'b0, bus.valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) n++;
    end
    chk("post_reset_quiet", n, 0);

    // Randomised ops with random gaps (gap 0 restarts in the DONE cycle).
    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 31);
      d = $urandom;
      drive(o, 5'(s), d);
      wait_valid(n, b);
      chk($sformatf("rnd%0d_latency", i), n, (s + 3) / 4);
      chk($sformatf("rnd%0d_result", i), bus.result, ref_shift(o, s, d));
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        if (bus.valid) begin
          errors++;
          $display("FAIL rnd%0d_extra_valid actual=1 required=0", i);
        end
        checks++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
